// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg
// Shared definitions for the machine-mode trap controller: FSM state encoding,
// exception/interrupt cause codes and the mtvec vectored-mode encoding.
// Imported by trap_ctrl and trap_cause_enc.
// Optional feature macro used by this slice: TRAP_VECTORED_EN (see trap_ctrl.sv).

package trap_ctrl_pkg;

    // Controller states: IDLE accepts commits, TRAP/RET each last one cycle
    // to strobe the CSR file, REDIR holds the fetch redirect until accepted.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAP  = 2'd1,
        ST_RET   = 2'd2,
        ST_REDIR = 2'd3
    } trap_state_e;

    // Exception codes (mcause with interrupt bit clear).
    localparam int unsigned TRAP_CAUSE_ECALL  = 11;
    localparam int unsigned TRAP_CAUSE_EBREAK = 3;

    // Machine timer interrupt code; the interrupt bit (MSB) is added by the
    // encoder because its position depends on XLEN.
    localparam int unsigned TRAP_CAUSE_MTIMER_CODE = 7;

    // mtvec[1:0] value selecting vectored interrupt dispatch.
    localparam logic [1:0] MTVEC_MODE_VEC = 2'b01;

endpackage : trap_ctrl_pkg

// File: rtl/trap_cause_enc.sv
// trap_cause_enc
// Combinational priority encoder for trap events at the commit boundary.
// Priority: ecall > ebreak > machine timer interrupt. An mret in the same
// commit counts as a synchronous event and suppresses the interrupt; the
// interrupt is re-evaluated on a later commit.
// Ports:
//   inst_valid   in   1     instruction commits this cycle
//   inst_ecall   in   1     committing instruction is ecall
//   inst_ebreak  in   1     committing instruction is ebreak
//   inst_mret    in   1     committing instruction is mret
//   irq_pending  in   1     timer interrupt pending and enabled
//   take         out  1     a trap is taken on this commit
//   cause        out  XLEN  mcause value for the taken trap
//   is_irq       out  1     taken trap is an interrupt (mepc = next PC)

module trap_cause_enc
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            inst_valid,
    input  logic            inst_ecall,
    input  logic            inst_ebreak,
    input  logic            inst_mret,
    input  logic            irq_pending,
    output logic            take,
    output logic [XLEN-1:0] cause,
    output logic            is_irq
);

    always_comb begin
        take   = 1'b0;
        cause  = '0;
        is_irq = 1'b0;
        if (inst_valid) begin
            if (inst_ecall) begin
                take  = 1'b1;
                cause = XLEN'(TRAP_CAUSE_ECALL);
            end else if (inst_ebreak) begin
                take  = 1'b1;
                cause = XLEN'(TRAP_CAUSE_EBREAK);
            end else if (!inst_mret && irq_pending) begin
                take   = 1'b1;
                is_irq = 1'b1;
                cause  = {1'b1, (XLEN-1)'(TRAP_CAUSE_MTIMER_CODE)};
            end
        end
    end

endmodule : trap_cause_enc

// File: rtl/trap_ctrl.sv
// trap_ctrl
// Sequences machine-mode trap entry and mret for the single-issue core.
// A committing ecall/ebreak/mret, or a committing instruction with a pending
// and enabled timer interrupt, moves the FSM out of IDLE. TRAP/RET drive a
// one-cycle CSR update strobe, then REDIR holds a PC redirect to fetch until
// redirect_ready. Commit is stalled whenever the FSM is not in IDLE.
// Configuration macro: TRAP_VECTORED_EN -- when defined, interrupts with
// mtvec[1:0]==2'b01 jump to base + 4*cause; otherwise always base.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   inst_valid/addr/nxt_pc           commit stage instruction info
//   inst_ecall/ebreak/mret           commit stage instruction type
//   clint_mtip                       timer interrupt pending (level)
//   mstatus_mie, mie_mtie            interrupt enables from CSR file
//   mtvec, mepc                      CSR file values
//   csr_trap_we/mepc/mcause          trap entry CSR update
//   csr_ret_we                       mret CSR update
//   commit_stall                     commit must not present inst_valid
//   redirect_valid/pc/ready          fetch redirect handshake

module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [ADDR_W-1:0] inst_nxt_pc,
    input  logic              inst_ecall,
    input  logic              inst_ebreak,
    input  logic              inst_mret,
    input  logic              clint_mtip,
    input  logic              mstatus_mie,
    input  logic              mie_mtie,
    input  logic [XLEN-1:0]   mtvec,
    input  logic [ADDR_W-1:0] mepc,
    output logic              csr_trap_we,
    output logic [ADDR_W-1:0] csr_trap_mepc,
    output logic [XLEN-1:0]   csr_trap_mcause,
    output logic              csr_ret_we,
    output logic              commit_stall,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    input  logic              redirect_ready
);

    trap_state_e       state_q, state_d;
    logic [ADDR_W-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0]   mcause_q, mcause_d;
    logic [ADDR_W-1:0] redirect_pc_q, redirect_pc_d;

    logic              irq_pending;
    logic              enc_take;
    logic [XLEN-1:0]   enc_cause;
    logic              enc_is_irq;
    logic [XLEN-1:0]   trap_base;
    logic [XLEN-1:0]   trap_target;

    assign irq_pending = clint_mtip & mstatus_mie & mie_mtie;

    trap_cause_enc #(
        .XLEN (XLEN)
    ) u_cause_enc (
        .inst_valid  (inst_valid),
        .inst_ecall  (inst_ecall),
        .inst_ebreak (inst_ebreak),
        .inst_mret   (inst_mret),
        .irq_pending (irq_pending),
        .take        (enc_take),
        .cause       (enc_cause),
        .is_irq      (enc_is_irq)
    );

    // Handler address. The latched cause (not the live encoder output) decides
    // vectoring because the target is computed in the TRAP cycle.
    always_comb begin
        trap_base   = mtvec & ~XLEN'(3);
        trap_target = trap_base;
`ifdef TRAP_VECTORED_EN
        if (mtvec[1:0] == MTVEC_MODE_VEC && mcause_q[XLEN-1]) begin
            trap_target = trap_base + {mcause_q[XLEN-3:0], 2'b00};
        end
`endif
    end

    // Next-state logic. Interrupts save the next PC so the interrupted
    // instruction is not re-executed; exceptions save the faulting PC.
    always_comb begin
        state_d       = state_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (enc_take) begin
                    mepc_d   = enc_is_irq ? inst_nxt_pc : inst_addr;
                    mcause_d = enc_cause;
                    state_d  = ST_TRAP;
                end else if (inst_valid && inst_mret) begin
                    state_d = ST_RET;
                end
            end
            ST_TRAP: begin
                redirect_pc_d = trap_target[ADDR_W-1:0];
                state_d       = ST_REDIR;
            end
            ST_RET: begin
                redirect_pc_d = mepc;
                state_d       = ST_REDIR;
            end
            ST_REDIR: begin
                if (redirect_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            mepc_q        <= '0;
            mcause_q      <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign csr_trap_we     = (state_q == ST_TRAP);
    assign csr_ret_we      = (state_q == ST_RET);
    assign redirect_valid  = (state_q == ST_REDIR);
    assign commit_stall    = (state_q != ST_IDLE);
    assign csr_trap_mepc   = mepc_q;
    assign csr_trap_mcause = mcause_q;
    assign redirect_pc     = redirect_pc_q;

endmodule : trap_ctrl
